// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_pkg
//  Purpose  : Shared types and constants for the reaction-timer controller:
//             FSM state encoding, BCD saturation value, LFSR seed and taps,
//             and the LFSR step function.
//  Revision : 1.0  initial release
// ============================================================================
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_RUN   = 3'd2,
        ST_SHOW  = 3'd3,
        ST_EARLY = 3'd4
    } state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16/14/13/11 expressed as bit positions 15/13/12/10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One shift of the 16-bit Fibonacci LFSR; feedback enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_ctrl_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_count4
//  Purpose  : 4-digit packed-BCD up-counter that saturates at 9999.
//  Ports    : clk, _reset (async, active-low)
//             clr       - synchronous clear to 0000 (wins over en)
//             en        - advance by one
//             count     - current value
//             count_inc - value the counter takes if en is asserted
//             max       - count is 9999
//  Revision : 1.0  initial release
// ============================================================================
module bcd_count4
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        _reset,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count,
    output logic [15:0] count_inc,
    output logic        max
);

    logic [15:0] r_count;
    logic [15:0] w_inc;
    logic        w_carry;

    // Ripple the +1 through the digits; a digit at 9 wraps to 0 and carries.
    always_comb begin
        w_inc   = r_count;
        w_carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (w_carry) begin
                if (r_count[4*d +: 4] == 4'd9) begin
                    w_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
        if (r_count == BCD_MAX) begin
            w_inc = BCD_MAX;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_count <= 16'h0000;
        end else if (clr) begin
            r_count <= 16'h0000;
        end else if (en) begin
            r_count <= w_inc;
        end
    end

    assign count     = r_count;
    assign count_inc = w_inc;
    assign max       = (r_count == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer_ctrl
//  Purpose  : Sequences a reaction-timer trial: 1 ms tick prescaler, random
//             arming delay from a free-running LFSR, cue LED, BCD millisecond
//             count, early-press / overflow detection and best-time tracking.
//  Ports    : clk, _reset (async, active-low)
//             start, stop        - single-cycle button pulses
//             led                - cue light, high only while timing
//             time_bcd, best_bcd - current/last and best time, packed BCD ms
//             early, ovr         - last trial aborted early / saturated
//  Revision : 1.0  initial release
// ============================================================================
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DELAY_MIN_MS = 1000,
    parameter int unsigned RAND_BITS    = 11
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic [15:0] time_bcd,
    output logic [15:0] best_bcd,
    output logic        early,
    output logic        ovr
);

    localparam int c_psc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_dly_w = $clog2(DELAY_MIN_MS + (2 ** RAND_BITS));

    localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(TICK_DIV - 1);
    localparam logic [c_psc_w-1:0] c_psc_one  = c_psc_w'(1);
    localparam logic [c_dly_w-1:0] c_dly_one  = c_dly_w'(1);
    localparam logic [c_dly_w-1:0] c_dly_min  = c_dly_w'(DELAY_MIN_MS);

    state_t               r_state, w_state_nxt;
    logic [15:0]          r_lfsr;
    logic [c_psc_w-1:0]   r_psc;
    logic [c_dly_w-1:0]   r_delay;
    logic                 r_led, r_early, r_ovr;
    logic [15:0]          r_best;

    logic                 w_tick;
    logic                 w_psc_clr, w_dly_load, w_cnt_clr, w_cnt_en;
    logic                 w_led_nxt, w_early_nxt, w_ovr_nxt;
    logic [15:0]          w_best_nxt;
    logic [15:0]          w_time, w_time_inc, w_time_final;
    logic                 w_time_max;

    assign w_tick = (r_psc == c_psc_last);

    // A stop that lands on a tick still counts that tick, so the frozen value
    // is the number of whole ticks elapsed at the stop sample.
    assign w_time_final = w_tick ? w_time_inc : w_time;

    bcd_count4 u_time (
        .clk       (clk),
        ._reset    (_reset),
        .clr       (w_cnt_clr),
        .en        (w_cnt_en),
        .count     (w_time),
        .count_inc (w_time_inc),
        .max       (w_time_max)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_psc_clr   = 1'b0;
        w_dly_load  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_led_nxt   = r_led;
        w_early_nxt = r_early;
        w_ovr_nxt   = r_ovr;
        w_best_nxt  = r_best;
        case (r_state)
            ST_IDLE, ST_SHOW, ST_EARLY: begin
                if (start) begin
                    w_state_nxt = ST_DELAY;
                    w_dly_load  = 1'b1;
                    w_psc_clr   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_early_nxt = 1'b0;
                    w_ovr_nxt   = 1'b0;
                    w_led_nxt   = 1'b0;
                end
            end
            ST_DELAY: begin
                if (stop) begin
                    w_state_nxt = ST_EARLY;
                    w_early_nxt = 1'b1;
                    w_led_nxt   = 1'b0;
                end else if (w_tick && (r_delay <= c_dly_one)) begin
                    w_state_nxt = ST_RUN;
                    w_psc_clr   = 1'b1;
                    w_led_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_SHOW;
                    w_led_nxt   = 1'b0;
                    w_cnt_en    = w_tick;
                    if (w_time_final < r_best) begin
                        w_best_nxt = w_time_final;
                    end
                end else if (w_tick) begin
                    if (w_time_max) begin
                        w_state_nxt = ST_SHOW;
                        w_ovr_nxt   = 1'b1;
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_lfsr  <= LFSR_SEED;
            r_psc   <= '0;
            r_delay <= '0;
            r_led   <= 1'b0;
            r_early <= 1'b0;
            r_ovr   <= 1'b0;
            r_best  <= BCD_MAX;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
            if (w_psc_clr || w_tick) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + c_psc_one;
            end
            if (w_dly_load) begin
                r_delay <= c_dly_min + c_dly_w'(r_lfsr[RAND_BITS-1:0]);
            end else if ((r_state == ST_DELAY) && w_tick && (r_delay != '0)) begin
                r_delay <= r_delay - c_dly_one;
            end
            r_led   <= w_led_nxt;
            r_early <= w_early_nxt;
            r_ovr   <= w_ovr_nxt;
            r_best  <= w_best_nxt;
        end
    end

    assign led      = r_led;
    assign time_bcd = w_time;
    assign best_bcd = r_best;
    assign early    = r_early;
    assign ovr      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reaction_timer_ctrl
//  Purpose  : Self-checking bench for reaction_timer_ctrl with a small tick
//             divider. A trial-level model predicts all outputs each cycle;
//             directed literal checks pin the key scenario results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reaction_timer_ctrl;

    localparam int TD   = 4;
    localparam int DMIN = 3;
    localparam int RB   = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        led;
    logic [15:0] time_bcd;
    logic [15:0] best_bcd;
    logic        early;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .TICK_DIV     (TD),
        .DELAY_MIN_MS (DMIN),
        .RAND_BITS    (RB)
    ) dut (
        .clk      (clk),
        ._reset   (reset_n),
        .start    (start),
        .stop     (stop),
        .led      (led),
        .time_bcd (time_bcd),
        .best_bcd (best_bcd),
        .early    (early),
        .ovr      (ovr)
    );

    // ---------------- trial-level model ----------------
    localparam int P_IDLE = 0, P_DELAY = 1, P_RUN = 2, P_SHOW = 3, P_EARLY = 4;

    int          m_phase = P_IDLE;
    int          m_cyc   = 0;
    int          m_t0    = 0;
    int          m_dly   = 0;
    int          m_rise  = 0;
    int          m_time  = 0;
    int          m_best  = 9999;
    bit          m_led   = 1'b0;
    bit          m_early = 1'b0;
    bit          m_ovr   = 1'b0;
    logic [15:0] m_lfsr  = 16'hACE1;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_time  = 0;
        m_best  = 9999;
        m_led   = 1'b0;
        m_early = 1'b0;
        m_ovr   = 1'b0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_step();
        int n;
        m_cyc++;
        case (m_phase)
            P_IDLE, P_SHOW, P_EARLY: begin
                if (start) begin
                    m_dly   = DMIN + int'(m_lfsr[RB-1:0]);
                    m_t0    = m_cyc;
                    m_phase = P_DELAY;
                    m_time  = 0;
                    m_early = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            P_DELAY: begin
                if (stop) begin
                    m_phase = P_EARLY;
                    m_early = 1'b1;
                end else if (m_cyc - m_t0 == m_dly * TD) begin
                    m_phase = P_RUN;
                    m_led   = 1'b1;
                    m_rise  = m_cyc;
                end
            end
            P_RUN: begin
                n = (m_cyc - m_rise) / TD;
                if (stop) begin
                    m_time  = (n > 9999) ? 9999 : n;
                    m_led   = 1'b0;
                    m_phase = P_SHOW;
                    if (m_time < m_best) m_best = m_time;
                end else if (n == 10000) begin
                    m_time  = 9999;
                    m_ovr   = 1'b1;
                    m_led   = 1'b0;
                    m_phase = P_SHOW;
                end else begin
                    m_time = n;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({led, time_bcd, best_bcd, early, ovr} !==
                {m_led, to_bcd(m_time), to_bcd(m_best), m_early, m_ovr}) begin
                errors++;
                $display("FAIL model_cmp t=%0t dut led=%b time=%h best=%h early=%b ovr=%b model led=%b time=%h best=%h early=%b ovr=%b",
                         $time, led, time_bcd, best_bcd, early, ovr,
                         m_led, to_bcd(m_time), to_bcd(m_best), m_early, m_ovr);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_led(input logic level, input int bound);
        int i;
        i = 0;
        while ((led !== level) && (i < bound)) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (led !== level) begin
            errors++;
            $display("FAIL led_wait: led=%b after %0d cycles, expected %b", led, i, level);
        end
    endtask

    // Called at the negedge where led was first seen high: the stop is
    // sampled k clock edges after the led rise edge.
    task automatic stop_after(input int k);
        repeat (k - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        repeat (100) @(negedge clk);
        check("rst_led",   16'(led),   16'h0);
        check("rst_time",  time_bcd,   16'h0000);
        check("rst_best",  best_bcd,   16'h9999);
        check("rst_early", 16'(early), 16'h0);
        check("rst_ovr",   16'(ovr),   16'h0);

        // Trial 1: stop 17 edges after cue -> 4 ms
        pulse_start();
        wait_led(1'b1, 100);
        stop_after(17);
        check("t1_led",  16'(led), 16'h0);
        check("t1_time", time_bcd, 16'h0004);
        check("t1_best", best_bcd, 16'h0004);

        // Early press during the arming delay
        pulse_start();
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("early_flag", 16'(early), 16'h1);
        check("early_time", time_bcd,   16'h0000);
        check("early_best", best_bcd,   16'h0004);
        repeat (60) @(negedge clk);
        check("early_led",  16'(led),   16'h0);
        pulse_start();
        check("early_clr",  16'(early), 16'h0);

        // Trial 2: 7 ms does not beat 4 ms
        wait_led(1'b1, 100);
        stop_after(29);
        check("t2_time", time_bcd, 16'h0007);
        check("t2_best", best_bcd, 16'h0004);

        // Trial 3: 2 ms becomes the new best
        pulse_start();
        wait_led(1'b1, 100);
        stop_after(9);
        check("t3_time", time_bcd, 16'h0002);
        check("t3_best", best_bcd, 16'h0002);

        // Overflow: no stop for 10000 ticks
        pulse_start();
        wait_led(1'b1, 100);
        wait_led(1'b0, 10000 * TD + 20);
        check("ovr_time", time_bcd, 16'h9999);
        check("ovr_flag", 16'(ovr), 16'h1);
        check("ovr_best", best_bcd, 16'h0002);
        pulse_start();
        check("ovr_clr",  16'(ovr), 16'h0);
        check("ovr_tclr", time_bcd, 16'h0000);

        // Asynchronous reset in the middle of a RUN
        wait_led(1'b1, 100);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_led",   16'(led),   16'h0);
        check("arst_time",  time_bcd,   16'h0000);
        check("arst_best",  best_bcd,   16'h9999);
        check("arst_early", 16'(early), 16'h0);
        check("arst_ovr",   16'(ovr),   16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // start and stop together from IDLE: start wins
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_early", 16'(early), 16'h0);
        wait_led(1'b1, 100);
        stop_after(5);
        check("ss_time", time_bcd, 16'h0001);
        check("ss_best", best_bcd, 16'h0001);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
